// File: rtl/uart_config_ctrl.sv
// UART link-configuration handshake controller: negotiates framing with the remote side
// as initiator or responder and owns the active line configuration.
module uart_config_ctrl #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       cfg_req_i,
    input  logic [5:0] cfg_new_i,
    input  logic       cfg_listen_i,
    output logic [7:0] tx_data_o,
    output logic       tx_valid_o,
    input  logic       tx_ready_i,
    input  logic [7:0] rx_data_i,
    input  logic       rx_valid_i,
    output logic       rx_ready_o,
    output logic [5:0] cfg_o,
    output logic       busy_o,
    output logic       cfg_done_o,
    output logic       cfg_fail_o
);

    typedef struct packed {
        logic [1:0] data_width;
        logic [1:0] parity_mode;
        logic [1:0] stop_bits;
    } uart_config_s;

    typedef enum logic [2:0] {
        IDLE,
        TX_SEND,
        TX_WAIT_ECHO,
        RX_WAIT,
        RX_ECHO,
        APPLY,
        FAIL
    } state_e;

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [1:0] END_CONFIGURATION_ID = 2'd0;
    localparam logic [1:0] DATA_WIDTH_ID        = 2'd1;
    localparam logic [1:0] PARITY_MODE_ID       = 2'd2;
    localparam logic [1:0] STOP_BITS_ID         = 2'd3;

    localparam uart_config_s STD_CONFIGURATION = 6'b11_00_00;

    function automatic logic [7:0] assemble_packet(input logic [1:0] id, input logic [1:0] option);
        return {4'b0000, option, id};
    endfunction

    function automatic logic [7:0] step_packet(input logic [1:0] step, input uart_config_s cfg);
        logic [7:0] pkt;
        case (step)
            2'd0:    pkt = assemble_packet(DATA_WIDTH_ID, cfg.data_width);
            2'd1:    pkt = assemble_packet(PARITY_MODE_ID, cfg.parity_mode);
            2'd2:    pkt = assemble_packet(STOP_BITS_ID, cfg.stop_bits);
            default: pkt = assemble_packet(END_CONFIGURATION_ID, 2'b00);
        endcase
        return pkt;
    endfunction

    state_e       state_q, state_d;
    logic [1:0]   step_q, step_d;
    uart_config_s shadow_q, shadow_d;
    uart_config_s cfg_q, cfg_d;
    logic         end_q, end_d;
    logic [7:0]   tx_data_q, tx_data_d;
    logic [TW-1:0] timer_q, timer_d;
    logic         tx_valid_q, tx_valid_d;
    logic         rx_ready_q, rx_ready_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         fail_q, fail_d;

    logic         tx_hs;
    logic         rx_hs;
    logic         timed_out;
    logic         counting;
    uart_config_s cfg_new;

    assign tx_hs     = tx_valid_q && tx_ready_i;
    assign rx_hs     = rx_ready_q && rx_valid_i;
    assign timed_out = (timer_q == TW'(TIMEOUT_CYCLES - 1));
    assign counting  = (state_q == TX_SEND) || (state_q == TX_WAIT_ECHO) ||
                       (state_q == RX_WAIT) || (state_q == RX_ECHO);
    assign cfg_new   = uart_config_s'(cfg_new_i);

    // Next-state logic; a handshake always leaves the wait state, so it naturally beats the timeout.
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        shadow_d  = shadow_q;
        cfg_d     = cfg_q;
        end_d     = end_q;
        tx_data_d = tx_data_q;

        case (state_q)
            IDLE: begin
                if (cfg_listen_i) begin
                    shadow_d = cfg_q;
                    end_d    = 1'b0;
                    state_d  = RX_WAIT;
                end else if (cfg_req_i) begin
                    if (cfg_new.stop_bits[1]) begin
                        state_d = FAIL;
                    end else begin
                        shadow_d  = cfg_new;
                        step_d    = 2'd0;
                        tx_data_d = step_packet(2'd0, cfg_new);
                        state_d   = TX_SEND;
                    end
                end
            end
            TX_SEND: begin
                if (tx_hs)          state_d = TX_WAIT_ECHO;
                else if (timed_out) state_d = FAIL;
            end
            TX_WAIT_ECHO: begin
                if (rx_hs) begin
                    if (rx_data_i[3:0] != tx_data_q[3:0]) begin
                        state_d = FAIL;
                    end else if (step_q == 2'd3) begin
                        state_d = APPLY;
                    end else begin
                        step_d    = step_q + 2'd1;
                        tx_data_d = step_packet(step_q + 2'd1, shadow_q);
                        state_d   = TX_SEND;
                    end
                end else if (timed_out) begin
                    state_d = FAIL;
                end
            end
            RX_WAIT: begin
                if (rx_hs) begin
                    tx_data_d = rx_data_i;
                    state_d   = RX_ECHO;
                    case (rx_data_i[1:0])
                        DATA_WIDTH_ID:  shadow_d.data_width  = rx_data_i[3:2];
                        PARITY_MODE_ID: shadow_d.parity_mode = rx_data_i[3:2];
                        STOP_BITS_ID: begin
                            if (rx_data_i[3]) begin
                                tx_data_d = tx_data_q;
                                state_d   = FAIL;
                            end else begin
                                shadow_d.stop_bits = rx_data_i[3:2];
                            end
                        end
                        default:        end_d = 1'b1;
                    endcase
                end else if (timed_out) begin
                    state_d = FAIL;
                end
            end
            RX_ECHO: begin
                if (tx_hs)          state_d = end_q ? APPLY : RX_WAIT;
                else if (timed_out) state_d = FAIL;
            end
            APPLY: begin
                cfg_d   = shadow_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        timer_d    = (state_d != state_q || !counting) ? '0 : timer_q + 1'b1;
        tx_valid_d = (state_d == TX_SEND) || (state_d == RX_ECHO);
        rx_ready_d = (state_d == TX_WAIT_ECHO) || (state_d == RX_WAIT);
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == APPLY);
        fail_d     = (state_d == FAIL);
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            step_q     <= 2'd0;
            shadow_q   <= STD_CONFIGURATION;
            cfg_q      <= STD_CONFIGURATION;
            end_q      <= 1'b0;
            tx_data_q  <= 8'h00;
            timer_q    <= '0;
            tx_valid_q <= 1'b0;
            rx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            shadow_q   <= shadow_d;
            cfg_q      <= cfg_d;
            end_q      <= end_d;
            tx_data_q  <= tx_data_d;
            timer_q    <= timer_d;
            tx_valid_q <= tx_valid_d;
            rx_ready_q <= rx_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            fail_q     <= fail_d;
        end
    end

    assign tx_data_o  = tx_data_q;
    assign tx_valid_o = tx_valid_q;
    assign rx_ready_o = rx_ready_q;
    assign cfg_o      = cfg_q;
    assign busy_o     = busy_q;
    assign cfg_done_o = done_q;
    assign cfg_fail_o = fail_q;

endmodule
